// File: rtl/gb_timing_pkg.sv
// Shared SM83 timing constants: one-hot T-state and M-cycle encodings.
// Imported by the cycle sequencer and by every microcode block.
// Pure declarations; no logic, latency or backpressure.
package gb_timing_pkg;

  localparam int STEPS      = 4;
  localparam int MAX_CYCLES = 8;

  typedef logic [STEPS-1:0]      step_t;
  typedef logic [MAX_CYCLES-1:0] count_t;

  // One-hot T-states within an M-cycle
  localparam step_t T1 = 4'b0001;
  localparam step_t T2 = 4'b0010;
  localparam step_t T3 = 4'b0100;
  localparam step_t T4 = 4'b1000;

  // One-hot M-cycle index within an instruction
  localparam count_t M_CYCLE_0 = 8'h01;
  localparam count_t M_CYCLE_1 = 8'h02;
  localparam count_t M_CYCLE_2 = 8'h04;
  localparam count_t M_CYCLE_3 = 8'h08;
  localparam count_t M_CYCLE_4 = 8'h10;
  localparam count_t M_CYCLE_5 = 8'h20;
  localparam count_t M_CYCLE_6 = 8'h40;
  localparam count_t M_CYCLE_7 = 8'h80;

  localparam step_t  STEP_RESET  = T1;
  localparam count_t COUNT_RESET = M_CYCLE_0;

endpackage

// File: rtl/cycle_sequencer_if.sv
// Timing bus between the cycle sequencer and the control unit.
// Outputs registered in the sequencer except o_Cycle_Start (decoded from step).
// No backpressure: i_Stall/i_Enable gate the sequencer directly.
interface cycle_sequencer_if #(
  parameter int STEPS      = 4,
  parameter int MAX_CYCLES = 8
);

  logic                  i_Enable;
  logic                  i_Stall;
  logic                  i_IR_Fetch;
  logic [STEPS-1:0]      o_Cycle_Step;
  logic [MAX_CYCLES-1:0] o_Cycle_Count;
  logic                  o_IR_Load;
  logic                  o_Force_Fetch;
  logic                  o_Cycle_Start;
  logic                  o_Sequence_Error;

  // Control-unit side: drives enables and fetch request, observes timing
  modport master (
    output i_Enable, i_Stall, i_IR_Fetch,
    input  o_Cycle_Step, o_Cycle_Count, o_IR_Load, o_Force_Fetch,
           o_Cycle_Start, o_Sequence_Error
  );

  // Sequencer side
  modport slave (
    input  i_Enable, i_Stall, i_IR_Fetch,
    output o_Cycle_Step, o_Cycle_Count, o_IR_Load, o_Force_Fetch,
           o_Cycle_Start, o_Sequence_Error
  );

endinterface

// File: rtl/onehot_ring.sv
// One-hot rotating ring register with synchronous clear to the reset pattern.
// Latency: one clock from i_Advance/i_Clear to o_Ring.
// No backpressure: holds whenever neither i_Advance nor i_Clear is high.
module onehot_ring #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Advance,
  input  logic             i_Clear,
  output logic [WIDTH-1:0] o_Ring
);

  logic [WIDTH-1:0] ring_q;
  logic [WIDTH-1:0] ring_d;

  // Clear wins over advance; advance is a left rotate so one-hot is preserved
  always_comb begin
    ring_d = ring_q;
    if (i_Clear) begin
      ring_d = RESET_VAL;
    end else if (i_Advance) begin
      ring_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
    end
  end

  // Ring state register with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      ring_q <= RESET_VAL;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign o_Ring = ring_q;

endmodule

// File: rtl/cycle_sequencer.sv
// T-state / M-cycle one-hot sequencer with fetch rollover, IR-load strobe and overrun flag.
// Latency: step/count registered; IR-load strobe visible the clock after the T4 edge.
// No backpressure: i_Stall freezes all state, i_Enable low holds state.
module cycle_sequencer
  import gb_timing_pkg::*;
#(
  parameter int STEPS      = 4,
  parameter int MAX_CYCLES = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  cycle_sequencer_if.slave   bus
);

  localparam logic [STEPS-1:0]      STEP_INIT  = STEPS'(1);
  localparam logic [MAX_CYCLES-1:0] COUNT_INIT = MAX_CYCLES'(1);

  logic [STEPS-1:0]      step_q;
  logic [MAX_CYCLES-1:0] count_q;

  logic advance;
  logic cycle_end;
  logic fetch_now;
  logic fetch_hit;
  logic count_clear;
  logic count_advance;

  logic fetch_pending_q, fetch_pending_d;
  logic force_fetch_q,   force_fetch_d;
  logic ir_load_q,       ir_load_d;
  logic seq_error_q,     seq_error_d;

  assign advance   = bus.i_Enable & ~bus.i_Stall;
  assign cycle_end = advance & step_q[STEPS-1];
  // The boot fetch is requested continuously until it completes
  assign fetch_now = bus.i_IR_Fetch | force_fetch_q;
  // A request seen at any T-state of this M-cycle, including the T4 clock itself
  assign fetch_hit = fetch_pending_q | fetch_now;

  assign count_clear   = cycle_end & fetch_hit;
  // Count saturates at the last M-cycle rather than wrapping to cycle 0
  assign count_advance = cycle_end & ~fetch_hit & ~count_q[MAX_CYCLES-1];

  onehot_ring #(
    .WIDTH     (STEPS),
    .RESET_VAL (STEP_INIT)
  ) u_step_ring (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Advance (advance),
    .i_Clear   (1'b0),
    .o_Ring    (step_q)
  );

  onehot_ring #(
    .WIDTH     (MAX_CYCLES),
    .RESET_VAL (COUNT_INIT)
  ) u_count_ring (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Advance (count_advance),
    .i_Clear   (count_clear),
    .o_Ring    (count_q)
  );

  // Next-state for fetch capture, boot fetch, IR strobe and sticky overrun
  always_comb begin
    fetch_pending_d = fetch_pending_q;
    force_fetch_d   = force_fetch_q;
    seq_error_d     = seq_error_q;
    ir_load_d       = 1'b0;
    if (count_clear) begin
      fetch_pending_d = 1'b0;
      force_fetch_d   = 1'b0;
      ir_load_d       = 1'b1;
    end else if (advance & fetch_now) begin
      fetch_pending_d = 1'b1;
    end
    if (cycle_end & ~fetch_hit & count_q[MAX_CYCLES-1]) begin
      seq_error_d = 1'b1;
    end
  end

  // Control/flag registers with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      fetch_pending_q <= 1'b0;
      force_fetch_q   <= 1'b1;
      ir_load_q       <= 1'b0;
      seq_error_q     <= 1'b0;
    end else begin
      fetch_pending_q <= fetch_pending_d;
      force_fetch_q   <= force_fetch_d;
      ir_load_q       <= ir_load_d;
      seq_error_q     <= seq_error_d;
    end
  end

  assign bus.o_Cycle_Step     = step_q;
  assign bus.o_Cycle_Count    = count_q;
  assign bus.o_IR_Load        = ir_load_q;
  assign bus.o_Force_Fetch    = force_fetch_q;
  assign bus.o_Cycle_Start    = step_q[0];
  assign bus.o_Sequence_Error = seq_error_q;

`ifdef SIM
  // Both timing vectors must remain one-hot outside reset
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      assert ($onehot(step_q))  else $error("cycle_sequencer: step not one-hot %b", step_q);
      assert ($onehot(count_q)) else $error("cycle_sequencer: count not one-hot %b", count_q);
    end
  end
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: boot fetch, 3-cycle instruction, stall,
// enable toggling, overrun saturation/stickiness and mid-instruction reset.
// Outputs sampled 1 time unit after each rising edge.
module tb_cycle_sequencer;
  import gb_timing_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  cycle_sequencer_if #(.STEPS(4), .MAX_CYCLES(8)) bus ();

  cycle_sequencer #(.STEPS(4), .MAX_CYCLES(8)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Step, count, IR-load strobe and cycle-start together
  task automatic chk_st(input string tag, input logic [3:0] st, input logic [7:0] cnt,
                        input logic irl);
    chk({tag, ".step"},  32'(bus.o_Cycle_Step),  32'(st));
    chk({tag, ".count"}, 32'(bus.o_Cycle_Count), 32'(cnt));
    chk({tag, ".irld"},  32'(bus.o_IR_Load),     32'(irl));
    chk({tag, ".start"}, 32'(bus.o_Cycle_Start), 32'(st[0]));
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst = 1'b1;
    bus.i_Enable   = 1'b0;
    bus.i_Stall    = 1'b0;
    bus.i_IR_Fetch = 1'b0;
    tick();
    tick();

    // Reset state
    chk_st("rst", T1, M_CYCLE_0, 1'b0);
    chk("rst.force", 32'(bus.o_Force_Fetch), 32'd1);
    chk("rst.err",   32'(bus.o_Sequence_Error), 32'd0);

    // Boot fetch cycle
    rst = 1'b0;
    bus.i_Enable = 1'b1;
    tick(); chk_st("boot.t2", T2, M_CYCLE_0, 1'b0);
    chk("boot.force", 32'(bus.o_Force_Fetch), 32'd1);
    tick(); chk_st("boot.t3", T3, M_CYCLE_0, 1'b0);
    tick(); chk_st("boot.t4", T4, M_CYCLE_0, 1'b0);
    tick(); chk_st("boot.end", T1, M_CYCLE_0, 1'b1);
    chk("boot.force_off", 32'(bus.o_Force_Fetch), 32'd0);
    tick(); chk_st("boot.after", T2, M_CYCLE_0, 1'b0);

    // 3-cycle instruction: cycles 01 and 02, then stall at 02/T3
    tick(); tick();
    tick(); chk_st("ins.c1", T1, M_CYCLE_1, 1'b0);
    tick(); tick(); chk_st("ins.c1t3", T3, M_CYCLE_1, 1'b0);
    bus.i_Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_st("stall", T3, M_CYCLE_1, 1'b0);
    end
    bus.i_Stall = 1'b0;
    tick(); chk_st("stall.rel", T4, M_CYCLE_1, 1'b0);
    tick(); chk_st("ins.c2", T1, M_CYCLE_2, 1'b0);
    tick(); tick(); chk_st("ins.c2t3", T3, M_CYCLE_2, 1'b0);
    bus.i_IR_Fetch = 1'b1;
    tick(); chk_st("ins.c2t4", T4, M_CYCLE_2, 1'b0);
    bus.i_IR_Fetch = 1'b0;
    tick(); chk_st("ins.roll", T1, M_CYCLE_0, 1'b1);
    tick(); chk_st("ins.roll2", T2, M_CYCLE_0, 1'b0);

    // Enable toggling: each T-state lasts two clocks
    bus.i_Enable = 1'b0; tick(); chk_st("tog.h2", T2, M_CYCLE_0, 1'b0);
    bus.i_Enable = 1'b1; tick(); chk_st("tog.a3", T3, M_CYCLE_0, 1'b0);
    bus.i_Enable = 1'b0; tick(); chk_st("tog.h3", T3, M_CYCLE_0, 1'b0);
    bus.i_Enable = 1'b1; bus.i_IR_Fetch = 1'b1;
    tick(); chk_st("tog.a4", T4, M_CYCLE_0, 1'b0);
    bus.i_Enable = 1'b0; bus.i_IR_Fetch = 1'b0;
    tick(); chk_st("tog.h4", T4, M_CYCLE_0, 1'b0);
    bus.i_Enable = 1'b1; tick(); chk_st("tog.end", T1, M_CYCLE_0, 1'b1);
    bus.i_Enable = 1'b0; tick(); chk_st("tog.h1", T1, M_CYCLE_0, 1'b0);
    bus.i_Enable = 1'b1; tick(); chk_st("tog.a2", T2, M_CYCLE_0, 1'b0);
    tick(); tick(); tick();
    chk_st("tog.c1", T1, M_CYCLE_1, 1'b0);

    // Overrun: no fetch, count walks to 80 and saturates
    for (int m = 2; m < 8; m++) begin
      repeat (4) tick();
      chk_st("ovr.walk", T1, 8'(1 << m), 1'b0);
    end
    chk("ovr.err0", 32'(bus.o_Sequence_Error), 32'd0);
    repeat (4) tick();
    chk_st("ovr.sat", T1, M_CYCLE_7, 1'b0);
    chk("ovr.err1", 32'(bus.o_Sequence_Error), 32'd1);
    repeat (4) tick();
    chk_st("ovr.hold", T1, M_CYCLE_7, 1'b0);
    chk("ovr.err_hold", 32'(bus.o_Sequence_Error), 32'd1);

    // Fetch recovers the count; error stays sticky
    bus.i_IR_Fetch = 1'b1; tick();
    bus.i_IR_Fetch = 1'b0; tick(); tick(); tick();
    chk_st("rec.roll", T1, M_CYCLE_0, 1'b1);
    chk("rec.err", 32'(bus.o_Sequence_Error), 32'd1);
    repeat (12) tick();
    tick();
    chk_st("rec.c3t2", T2, M_CYCLE_3, 1'b0);

    // Mid-instruction reset
    rst = 1'b1; tick(); rst = 1'b0;
    chk_st("mrst", T1, M_CYCLE_0, 1'b0);
    chk("mrst.force", 32'(bus.o_Force_Fetch), 32'd1);
    chk("mrst.err",   32'(bus.o_Sequence_Error), 32'd0);
    repeat (4) tick();
    chk_st("mrst.boot", T1, M_CYCLE_0, 1'b1);
    chk("mrst.force_off", 32'(bus.o_Force_Fetch), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
